// File: rtl/adxl362_sequencer_if.sv
// Byte-level handshake between the ADXL362 transaction sequencer and the SPI
// byte controller. The sequencer is the master: it launches one byte at a time
// and the controller answers with busy/done and the received byte.
interface adxl362_sequencer_if;
  logic       spi_start;
  logic [7:0] spi_data_out;
  logic       spi_hold_cs;
  logic       spi_busy;
  logic       spi_done;
  logic [7:0] spi_data_in;

  modport master (
    output spi_start, spi_data_out, spi_hold_cs,
    input  spi_busy, spi_done, spi_data_in
  );

  modport slave (
    input  spi_start, spi_data_out, spi_hold_cs,
    output spi_busy, spi_done, spi_data_in
  );
endinterface

// File: rtl/adxl362_sequencer.sv
// ADXL362 transaction sequencer: puts the sensor into measurement mode after
// reset, then arbitrates the SPI link between manual register accesses and a
// periodic X/Y/Z burst read, issuing one byte per SPI controller transfer.
module adxl362_sequencer #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int SAMPLE_HZ     = 100
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       man_req,
  input  logic       man_write,
  input  logic [7:0] man_addr,
  input  logic [7:0] man_wdata,
  output logic       man_busy,
  output logic       man_done,
  output logic [7:0] man_rdata,
  input  logic       auto_en,
  output logic [7:0] x_data,
  output logic [7:0] y_data,
  output logic [7:0] z_data,
  output logic       sample_valid,
  adxl362_sequencer_if.master spi
);

  localparam int PERIOD = CLK_FREQUENCY / SAMPLE_HZ;
  localparam int TMR_W  = $clog2(PERIOD);

  typedef enum logic [2:0] {
    S_INIT, S_IDLE, S_LOAD, S_START, S_WAIT, S_FINISH
  } state_t;

  typedef enum logic [1:0] {
    K_INIT, K_WR, K_RD, K_AUTO
  } kind_t;

  state_t           state;
  kind_t            kind;
  logic [2:0]       idx;
  logic             adv;
  logic             pending;
  logic             man_req_q;
  logic [7:0]       addr_q;
  logic [7:0]       wdata_q;
  logic             start_r;
  logic [7:0]       dout_r;
  logic             hold_r;
  logic [TMR_W-1:0] timer;
  logic             tc;

  // Byte i of the transaction of kind k.
  function automatic logic [7:0] seq_byte(kind_t k, logic [2:0] i,
                                          logic [7:0] a, logic [7:0] w);
    logic [7:0] b;
    case (k)
      K_INIT:  b = (i == 3'd0) ? 8'h0A : (i == 3'd1) ? 8'h2D : 8'h02;
      K_WR:    b = (i == 3'd0) ? 8'h0A : (i == 3'd1) ? a     : w;
      K_RD:    b = (i == 3'd0) ? 8'h0B : (i == 3'd1) ? a     : 8'h00;
      default: b = (i == 3'd0) ? 8'h0B : (i == 3'd1) ? 8'h08 : 8'h00;
    endcase
    return b;
  endfunction

  // Index of the final byte; the auto burst reads three data registers.
  function automatic logic [2:0] last_idx(kind_t k);
    return (k == K_AUTO) ? 3'd4 : 3'd2;
  endfunction

  assign tc               = (timer == TMR_W'(PERIOD - 1));
  assign man_busy         = (state != S_IDLE);
  assign spi.spi_start    = start_r;
  assign spi.spi_data_out = dout_r;
  assign spi.spi_hold_cs  = hold_r;

  // Free-running sample timer, independent of the FSM state.
  always_ff @(posedge clk) begin
    if (rst || tc) timer <= '0;
    else           timer <= timer + TMR_W'(1);
  end

  // Transaction FSM with pending-sample flag, arbitration and data capture.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_INIT;
      kind         <= K_INIT;
      idx          <= 3'd0;
      adv          <= 1'b0;
      pending      <= 1'b0;
      man_req_q    <= 1'b0;
      addr_q       <= 8'h00;
      wdata_q      <= 8'h00;
      start_r      <= 1'b0;
      dout_r       <= 8'h00;
      hold_r       <= 1'b0;
      man_done     <= 1'b0;
      sample_valid <= 1'b0;
      man_rdata    <= 8'h00;
      x_data       <= 8'h00;
      y_data       <= 8'h00;
      z_data       <= 8'h00;
    end else begin
      man_req_q    <= man_req;
      start_r      <= 1'b0;
      man_done     <= 1'b0;
      sample_valid <= 1'b0;
      // Expiries merge into a single pending request.
      if (!auto_en) pending <= 1'b0;
      else if (tc)  pending <= 1'b1;

      case (state)
        S_INIT, S_LOAD: begin
          idx <= 3'd0;
          adv <= 1'b0;
          if (!spi.spi_busy) begin
            state   <= S_START;
            start_r <= 1'b1;
            dout_r  <= seq_byte(kind, 3'd0, addr_q, wdata_q);
            hold_r  <= 1'b1;
          end
        end
        S_IDLE: begin
          // Only a fresh edge counts, so a stuck-high man_req cannot starve auto.
          if (man_req && !man_req_q) begin
            kind    <= man_write ? K_WR : K_RD;
            addr_q  <= man_addr;
            wdata_q <= man_wdata;
            state   <= S_LOAD;
          end else if (pending && auto_en) begin
            kind    <= K_AUTO;
            state   <= S_LOAD;
            pending <= tc;
          end
        end
        S_START: state <= S_WAIT;
        S_WAIT: begin
          if (adv) begin
            // One spare cycle after spi_done before launching the next byte.
            if (!spi.spi_busy) begin
              state   <= S_START;
              start_r <= 1'b1;
              dout_r  <= seq_byte(kind, idx, addr_q, wdata_q);
              hold_r  <= (idx != last_idx(kind));
              adv     <= 1'b0;
            end
          end else if (spi.spi_done) begin
            if (kind == K_RD && idx == 3'd2) man_rdata <= spi.spi_data_in;
            if (kind == K_AUTO) begin
              if (idx == 3'd2) x_data <= spi.spi_data_in;
              if (idx == 3'd3) y_data <= spi.spi_data_in;
              if (idx == 3'd4) z_data <= spi.spi_data_in;
            end
            if (idx == last_idx(kind)) begin
              state <= S_FINISH;
            end else begin
              idx <= idx + 3'd1;
              adv <= 1'b1;
            end
          end
        end
        S_FINISH: begin
          if (kind == K_AUTO)      sample_valid <= 1'b1;
          else if (kind != K_INIT) man_done     <= 1'b1;
          state <= S_IDLE;
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: doc/adxl362_sequencer.md
# adxl362_sequencer

Transaction sequencer and arbiter between the byte-level SPI controller and the ADXL362 accelerometer. After reset it puts the sensor in measurement mode. It then shares the SPI link between two requesters: manual register read/write requests (switches/buttons from the top level) and a periodic automatic burst read of the X/Y/Z 8-bit data registers. It sits between the top-level I/O logic and the SPI controller, which it drives one byte at a time.

## Interface

- CLK_FREQUENCY, 100_000_000: clk frequency in Hz.
- SAMPLE_HZ, 100: automatic sample rate in Hz. PERIOD = CLK_FREQUENCY/SAMPLE_HZ cycles; PERIOD must be ≥ 2.
- clk  in  1  system clock; everything is rising-edge.
- rst  in  1  synchronous, active-high reset.
- man_req  in  1  manual request; sampled only in IDLE, ignored otherwise.
- man_write  in  1  1 = register write, 0 = register read; sampled with man_req.
- man_addr  in  8  register address; sampled with man_req.
- man_wdata  in  8  write data; sampled with man_req.
- man_busy  out  1  high whenever state ≠ IDLE.
- man_done  out  1  one-cycle pulse when a manual transaction completes.
- man_rdata  out  8  read data from the last manual read; unchanged by writes.
- auto_en  in  1  enables periodic sampling.
- x_data, y_data, z_data  out  8 each  last sampled XDATA/YDATA/ZDATA.
- sample_valid  out  1  one-cycle pulse when x/y/z update.
- spi_start  out  1  one-cycle pulse that starts one byte transfer.
- spi_data_out  out  8  byte to send.
- spi_hold_cs  out  1  keep CS low after this byte.
- spi_busy  in  1  SPI controller busy.
- spi_done  in  1  one-cycle pulse at the end of a byte transfer.
- spi_data_in  in  8  received byte; valid when spi_done is high.

## Operation

- Transaction types are byte sequences. The last byte always has spi_hold_cs=0; all other bytes have spi_hold_cs=1.
  - INIT: 0x0A, 0x2D, 0x02. This writes POWER_CTL to measurement mode.
  - Manual write: 0x0A, man_addr, man_wdata.
  - Manual read: 0x0B, man_addr, 0x00. The third received byte goes to man_rdata.
  - Auto: 0x0B, 0x08, 0x00, 0x00, 0x00. Received bytes 3, 4 and 5 go to x_data, y_data and z_data.
- FSM states: INIT, IDLE, LOAD, START, WAIT, FINISH.
  - Reset enters INIT, which behaves as LOAD with the INIT sequence.
  - IDLE → LOAD on man_req. Otherwise IDLE → LOAD if the pending flag is set.
  - LOAD latches the sequence and a byte index of 0.
  - START is entered only when spi_busy=0. It drives spi_start=1 for exactly one cycle.
  - WAIT holds until spi_done. On spi_done it captures the received byte when applicable, then either increments the index and returns to START, or goes to FINISH after the last byte.
  - FINISH pulses man_done (manual) or sample_valid (auto), or does neither (INIT), then goes to IDLE.
- spi_data_out and spi_hold_cs are registered. They are valid in the spi_start cycle and stay stable until spi_done.
- Sample timer:
  - Free-running counter 0..PERIOD-1. It runs in every state.
  - At the terminal count with auto_en=1, it sets the pending flag.
  - Only one pending request is kept; extra expiries merge into it.
  - The pending flag clears when the auto transaction enters LOAD, or in any cycle where auto_en=0.
- Arbitration:
  - Manual has priority over pending auto when both are present in the same IDLE cycle. The auto transaction then runs next.
  - A man_req held high continuously does not starve auto: a manual request is accepted only on a rising edge of man_req.
- man_req arriving while busy is dropped. It is not queued.

## Timing

- Reset values: man_busy=1 (state INIT). All other outputs are 0: man_done, man_rdata, x/y/z_data, sample_valid, spi_start, spi_data_out, spi_hold_cs. Timer and pending flag are 0.
- man_req rising edge in IDLE (cycle N) → LOAD at N+1 → spi_start at N+2, provided spi_busy=0.
- Data captures (man_rdata, x/y/z_data) are registered on the cycle after spi_done. The done or valid pulse comes one cycle after the capture of the last byte.
- Between bytes, at least one idle cycle (WAIT → START) separates spi_done from the next spi_start.
- man_busy falls in the same cycle the FSM returns to IDLE.
- A reset mid-transaction must:
  - abort immediately;
  - drop spi_start the next cycle;
  - clear pending and the timer;
  - rerun INIT;
  - leave captured data registers at 0.
- Widths: the timer is $clog2(PERIOD) bits, and the byte index is 3 bits.

## Test plan

- Reset, with the SPI responder acking each byte after 20 cycles → bytes 0x0A, 0x2D, 0x02 with hold_cs 1, 1, 0. man_busy is 1 until IDLE, and no man_done pulse occurs.
- Manual read of addr 0x00 (responder returns 0xAD), then addr 0x02 (returns 0xF2) → man_rdata is 0xAD, then 0xF2, each with one man_done pulse. spi_start comes 2 cycles after the man_req edge.
- Manual write man_addr=0x1F, man_wdata=0x52 → bytes 0x0A, 0x1F, 0x52 with hold_cs 1, 1, 0. man_rdata is unchanged and man_done pulses once.
- CLK_FREQUENCY=1000, SAMPLE_HZ=10, auto_en=1, responder returns 0x11, 0x22, 0x33 → bytes 0x0B, 0x08, 0x00×3 every 100 cycles. x/y/z_data read 0x11/0x22/0x33 with a sample_valid pulse. With auto_en=0, no auto traffic.
- man_req edge in the same IDLE cycle as pending set → manual transaction first, then the auto burst immediately after. A second man_req during the burst is dropped.
- rst asserted during byte 2 of a manual read → spi_start=0 next cycle, all outputs at reset values, and the INIT sequence reissued.
